sqrt_arbiter: RTL
=================

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester ports.
REQ-002 Parameter IN_W, default 16, SHALL set the operand width.
REQ-003 Parameter OUT_W, default 8, SHALL set the root width.
REQ-004 Parameter TIMEOUT, default 64, SHALL set the maximum number of WAIT cycles before abort.
REQ-005 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port req_valid, input, NUM_REQ: per-requester operand valid.
REQ-008 Port req_data, input, NUM_REQ*IN_W: operands; requester i occupies bits [i*IN_W +: IN_W].
REQ-009 Port req_ready, output, NUM_REQ: per-requester accept, at most one bit high.
REQ-010 Port rsp_valid, output, 1: result available.
REQ-011 Port rsp_ready, input, 1: consumer accepts result.
REQ-012 Port rsp_id, output, clog2(NUM_REQ): index of the requester that owns the result.
REQ-013 Port rsp_root, output, OUT_W: root value.
REQ-014 Port rsp_error, output, 1: error flag, either from the unit or from timeout.
REQ-015 Port rsp_timeout, output, 1: abort caused by timeout.
REQ-016 Port sq_start, output, 1: start pulse to the shared sqrt unit.
REQ-017 Port sq_in, output, IN_W: operand to the sqrt unit.
REQ-018 Port sq_out, input, OUT_W: sqrt unit root.
REQ-019 Port sq_error, input, 1: sqrt unit error (negative operand).
REQ-020 Port sq_done, input, 1: sqrt unit completion.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-022 IDLE with any req_valid high: grant the first valid index at or after rr_ptr, searching cyclically; assert req_ready[g] combinationally in that same cycle; latch req_data slice g and id g; go to ISSUE.
REQ-023 req_ready SHALL be all-zero in every state except IDLE.
REQ-024 On grant, rr_ptr SHALL become (g+1) mod NUM_REQ; non-granted requests SHALL remain pending without loss.
REQ-025 ISSUE: sq_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
REQ-026 sq_in SHALL hold the latched operand, stable from ISSUE through the end of WAIT.
REQ-027 WAIT: on the first cycle sq_done=1, latch sq_out into rsp_root and sq_error into rsp_error, set rsp_timeout=0, and go to RESP.
REQ-028 WAIT: the counter increments each cycle; if it reaches TIMEOUT-1 with sq_done=0, set rsp_error=1, rsp_timeout=1, rsp_root=0, and go to RESP.
REQ-029 sq_done and timeout in the same cycle: sq_done SHALL win.
REQ-030 sq_done outside WAIT SHALL be ignored.
REQ-031 RESP: rsp_valid=1 with rsp_id, rsp_root, rsp_error and rsp_timeout stable until rsp_ready=1; on handshake go to IDLE.
REQ-032 No new grant SHALL occur in the same cycle as the RESP handshake; minimum spacing between grants is 4 cycles.
REQ-033 Latency: grant at cycle t, sq_start at t+1, earliest rsp_valid at t+3 when sq_done arrives at t+2.

Reset
REQ-034 rst=1 SHALL immediately force state=IDLE, rr_ptr=0, counter=0, and sq_start, sq_in, rsp_valid, rsp_id, rsp_root, rsp_error and rsp_timeout to 0; req_ready SHALL follow req_valid only after release.
REQ-035 Reset mid-operation SHALL discard the in-flight request without issuing any response.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, default parameter values and the id-width function.
REQ-037 The rotating priority pick SHALL be one sub-module, rr_pick (inputs valid and ptr; outputs onehot grant and index).
REQ-038 The sqrt unit SHALL be instantiated outside this block and connected by the bench.

Verification
REQ-039 Single request: req_valid=0001, data 16; sqrt model done after 5 cycles -> one sq_start pulse with sq_in=16, then rsp_id=0, root=4, error=0.
REQ-040 All four requesters valid with data 16, 25, 0, 18 -> grant order 0, 1, 2, 3; roots 4, 5, 0, 4; errors all 0.
REQ-041 Negative operand 0xFFF6 with model sq_error=1 -> rsp_error=1, rsp_timeout=0.
REQ-042 Model never asserts done, TIMEOUT=64 -> rsp_valid exactly 64 cycles after sq_start, error=1, timeout=1, root=0.
REQ-043 Backpressure: rsp_ready held 0 for 10 cycles -> rsp fields stable, req_ready=0 throughout, no second sq_start.
REQ-044 rst asserted during WAIT -> outputs zero in the same cycle, no response emitted, next grant starts at requester 0.

Source files
------------

// File: rtl/sqrt_arbiter_pkg.sv
// Shared types and defaults for the sqrt request arbiter.
// The id-width helper keeps single-requester builds at a 1-bit id.
package sqrt_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_IN_W    = 16;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_TIMEOUT = 64;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// Rotating-priority pick: first valid index at or after ptr, searching cyclically.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index,
    output logic               found
);

    int cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared sqrt unit, one operation at a time,
// with a wait-cycle timeout that reports an error response instead of hanging.
module sqrt_arbiter
    import sqrt_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W   = id_w(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [OUT_W-1:0]        rsp_root,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    sq_start,
    output logic [IN_W-1:0]         sq_in,
    input  logic [OUT_W-1:0]        sq_out,
    input  logic                    sq_error,
    input  logic                    sq_done
);

    // Counter only needs to reach TIMEOUT-2: the abort fires when the next value would be TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sq_start_q, sq_start_d;
    logic [IN_W-1:0]     sq_in_q, sq_in_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [OUT_W-1:0]    rsp_root_q, rsp_root_d;
    logic                rsp_error_q, rsp_error_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_found;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .index (pick_idx),
        .found (pick_found)
    );

    assign req_ready   = (state_q == S_IDLE && !rst) ? pick_grant : '0;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_root    = rsp_root_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign sq_start    = sq_start_q;
    assign sq_in       = sq_in_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        sq_start_d    = sq_start_q;
        sq_in_d       = sq_in_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_root_d    = rsp_root_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    sq_in_d    = req_data[int'(pick_idx)*IN_W +: IN_W];
                    rsp_id_d   = pick_idx;
                    rr_ptr_d   = (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + ID_W'(1);
                    sq_start_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sq_start_d = 1'b0;
                cnt_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sq_done) begin
                    rsp_root_d    = sq_out;
                    rsp_error_d   = sq_error;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT-2)) begin
                    rsp_root_d    = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            sq_start_q    <= 1'b0;
            sq_in_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_root_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            sq_start_q    <= sq_start_d;
            sq_in_q       <= sq_in_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_root_q    <= rsp_root_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule
